// File: rtl/four_bit_sdc_pkg.sv
// four_bit_sdc_pkg: shared state encodings and default counter width for the counter library
package four_bit_sdc_pkg;
  localparam int SDC_WIDTH = 4;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/four_bit_sdc_if.sv
// four_bit_sdc_if: counter bus; master drives load/d/mode/en, slave returns q/tc/busy
interface four_bit_sdc_if import four_bit_sdc_pkg::*; #(parameter int WIDTH = SDC_WIDTH);
  logic             load;
  logic [WIDTH-1:0] d;
  logic             mode;
  logic             en;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  modport master(output load, d, mode, en, input q, tc, busy);
  modport slave(input load, d, mode, en, output q, tc, busy);
endinterface

// File: rtl/four_bit_sdc.sv
// four_bit_sdc: loadable down counter/timer (clk, async reset, bus: load/d/mode/en in, q/tc/busy out), one-shot or periodic
module four_bit_sdc import four_bit_sdc_pkg::*; #(
  parameter int WIDTH = SDC_WIDTH
) (
  input logic            clk,
  input logic            reset,
  four_bit_sdc_if.slave  bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  state_t           st_q, st_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, rel_q, rel_d;
  logic             mode_q, mode_d, tc_q, tc_d;
  logic             run_en;
  assign run_en = (st_q == RUN) && bus.en;
  always_comb begin
    cnt_d  = cnt_q;
    rel_d  = rel_q;
    mode_d = mode_q;
    st_d   = st_q;
    tc_d   = 1'b0;
    if (bus.load) begin
      cnt_d  = bus.d;
      rel_d  = bus.d;
      mode_d = bus.mode;
      st_d   = (bus.d != '0) ? RUN : IDLE;
    end else if (run_en && cnt_q > ONE) begin
      cnt_d = cnt_q - ONE;
    end else if (run_en && cnt_q == ONE) begin
      tc_d  = 1'b1;
      cnt_d = mode_q ? rel_q : '0;
      st_d  = mode_q ? RUN : IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      rel_q  <= '0;
      mode_q <= 1'b0;
      tc_q   <= 1'b0;
      st_q   <= IDLE;
    end else begin
      cnt_q  <= cnt_d;
      rel_q  <= rel_d;
      mode_q <= mode_d;
      tc_q   <= tc_d;
      st_q   <= st_d;
    end
  end
  assign bus.q    = cnt_q;
  assign bus.tc   = tc_q;
  assign bus.busy = (st_q == RUN);
endmodule
